// File: rtl/lock_sequencer.sv
// Keypad lock sequencer.
// Four BCD digits are collected on enter presses and compared against a
// programmable code. The lock opens on a match. Wrong codes flash an error,
// and repeated failures force a timed lockout. While open, a new code can be
// programmed. All timing is counted in pulses of the slow tick enable.
module lock_sequencer #(
  parameter logic [15:0] DEFAULT_CODE  = 16'h1234,
  parameter int          MAX_TRIES     = 3,
  parameter int          LOCKOUT_TICKS = 20,
  parameter int          OPEN_TICKS    = 10,
  parameter int          ERR_TICKS     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [3:0] in_digit,
  input  logic       enter_btn,
  input  logic       set_btn,
  output logic       locked_led,
  output logic       unlocked_led,
  output logic       error_led,
  output logic       lockout_led,
  output logic [2:0] state,
  output logic [1:0] digit_idx,
  output logic [1:0] attempts
);

  typedef enum logic [2:0] {
    StLocked  = 3'd0,
    StEntry   = 3'd1,
    StVerify  = 3'd2,
    StOpen    = 3'd3,
    StError   = 3'd4,
    StLockout = 3'd5,
    StProgram = 3'd6,
    StIllegal = 3'd7
  } state_e;

  // The tick counter must hold the longest of the three durations.
  localparam int MaxOpenErr = (OPEN_TICKS > ERR_TICKS) ? OPEN_TICKS : ERR_TICKS;
  localparam int CntMax     = (LOCKOUT_TICKS > MaxOpenErr) ? LOCKOUT_TICKS : MaxOpenErr;
  localparam int CntW       = (CntMax < 2) ? 1 : $clog2(CntMax + 1);

  // Each timeout fires on the tick that completes its duration, which is
  // the tick seen while the counter holds duration-1.
  localparam logic [CntW-1:0] ErrLast     = CntW'(ERR_TICKS - 1);
  localparam logic [CntW-1:0] LockoutLast = CntW'(LOCKOUT_TICKS - 1);
  localparam logic [CntW-1:0] OpenLast    = CntW'(OPEN_TICKS - 1);
  localparam logic [1:0]      MaxTries    = 2'(MAX_TRIES);

  state_e            state_q, state_d;
  logic [1:0]        digitIdx_q, digitIdx_d;
  logic [1:0]        attempts_q, attempts_d;
  logic [15:0]       digits_q, digits_d;
  logic [15:0]       code_q, code_d;
  logic [CntW-1:0]   tickCnt_q, tickCnt_d;

  logic [1:0]        enterSync_q;
  logic              enterPrev_q;
  logic [1:0]        setSync_q;
  logic              setPrev_q;

  logic              enterPress;
  logic              setPressRaw;
  logic              setPress;
  logic [15:0]       capturedDigits;
  logic [1:0]        attemptsInc;
  logic              tickExpired;

  // Two-flop synchronisers for the raw buttons, plus a delayed copy of the
  // synchronised level so a rising edge becomes a single-clk press event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enterSync_q <= 2'b00;
      enterPrev_q <= 1'b0;
      setSync_q   <= 2'b00;
      setPrev_q   <= 1'b0;
    end else begin
      enterSync_q <= {enterSync_q[0], enter_btn};
      enterPrev_q <= enterSync_q[1];
      setSync_q   <= {setSync_q[0], set_btn};
      setPrev_q   <= setSync_q[1];
    end
  end

  assign enterPress  = enterSync_q[1] & ~enterPrev_q;
  assign setPressRaw = setSync_q[1] & ~setPrev_q;
  // Enter wins whenever both buttons fire in the same clk.
  assign setPress    = setPressRaw & ~enterPress;

  assign attemptsInc = (attempts_q == 2'd3) ? 2'd3 : attempts_q + 2'd1;

  // Place the current digit into the slot selected by digit_idx, with slot 0
  // being the most-significant nibble (first digit typed).
  always_comb begin
    capturedDigits = digits_q;
    case (digitIdx_q)
      2'd0:    capturedDigits[15:12] = in_digit;
      2'd1:    capturedDigits[11:8]  = in_digit;
      2'd2:    capturedDigits[7:4]   = in_digit;
      default: capturedDigits[3:0]   = in_digit;
    endcase
  end

  // Decide whether the tick in this clk completes the current state's wait.
  always_comb begin
    tickExpired = 1'b0;
    case (state_q)
      StError:   tickExpired = tick && (tickCnt_q == ErrLast);
      StLockout: tickExpired = tick && (tickCnt_q == LockoutLast);
      StOpen:    tickExpired = tick && (tickCnt_q == OpenLast);
      default:   tickExpired = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StLocked;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, together with the digit, attempt and code updates
  // that belong to each transition.
  always_comb begin
    state_d    = state_q;
    digitIdx_d = digitIdx_q;
    attempts_d = attempts_q;
    digits_d   = digits_q;
    code_d     = code_q;
    case (state_q)
      StLocked: begin
        if (enterPress) begin
          digits_d   = capturedDigits;
          digitIdx_d = 2'd1;
          state_d    = StEntry;
        end
      end
      StEntry: begin
        if (enterPress) begin
          digits_d   = capturedDigits;
          digitIdx_d = digitIdx_q + 2'd1;
          if (digitIdx_q == 2'd3) begin
            state_d = StVerify;
          end
        end
      end
      StVerify: begin
        if (digits_q == code_q) begin
          attempts_d = 2'd0;
          state_d    = StOpen;
        end else begin
          attempts_d = attemptsInc;
          state_d    = (attemptsInc == MaxTries) ? StLockout : StError;
        end
      end
      StError: begin
        if (tickExpired) begin
          state_d = StLocked;
        end
      end
      StLockout: begin
        if (tickExpired) begin
          attempts_d = 2'd0;
          state_d    = StLocked;
        end
      end
      StOpen: begin
        if (enterPress) begin
          state_d = StLocked;
        end else if (setPress) begin
          digitIdx_d = 2'd0;
          state_d    = StProgram;
        end else if (tickExpired) begin
          state_d = StLocked;
        end
      end
      StProgram: begin
        if (enterPress) begin
          digits_d   = capturedDigits;
          digitIdx_d = digitIdx_q + 2'd1;
          if (digitIdx_q == 2'd3) begin
            code_d  = capturedDigits;
            state_d = StOpen;
          end
        end else if (setPress) begin
          digitIdx_d = 2'd0;
          state_d    = StOpen;
        end
      end
      default: begin
        digitIdx_d = 2'd0;
        state_d    = StLocked;
      end
    endcase
  end

  // The tick counter restarts on every state change, so a tick landing on
  // the entry edge is not counted toward the new state's wait.
  always_comb begin
    tickCnt_d = tickCnt_q;
    if (state_d != state_q) begin
      tickCnt_d = '0;
    end else if (tick) begin
      tickCnt_d = tickCnt_q + CntW'(1);
    end
  end

  // Datapath registers: captured digits, stored code, counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digitIdx_q <= 2'd0;
      attempts_q <= 2'd0;
      digits_q   <= 16'h0000;
      code_q     <= DEFAULT_CODE;
      tickCnt_q  <= '0;
    end else begin
      digitIdx_q <= digitIdx_d;
      attempts_q <= attempts_d;
      digits_q   <= digits_d;
      code_q     <= code_d;
      tickCnt_q  <= tickCnt_d;
    end
  end

  // Moore status outputs decoded straight from the state register, so they
  // follow reset without waiting for a clock.
  always_comb begin
    locked_led   = 1'b0;
    unlocked_led = 1'b0;
    error_led    = 1'b0;
    lockout_led  = 1'b0;
    case (state_q)
      StLocked, StEntry, StVerify: locked_led = 1'b1;
      StOpen, StProgram:           unlocked_led = 1'b1;
      StError:                     error_led = 1'b1;
      StLockout: begin
        error_led   = 1'b1;
        lockout_led = 1'b1;
      end
      default: begin
        locked_led = 1'b0;
      end
    endcase
  end

  assign state     = state_q;
  assign digit_idx = digitIdx_q;
  assign attempts  = attempts_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed testbench for lock_sequencer.
module tb_lock_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [3:0] in_digit;
  logic       enter_btn;
  logic       set_btn;
  logic       locked_led;
  logic       unlocked_led;
  logic       error_led;
  logic       lockout_led;
  logic [2:0] state;
  logic [1:0] digit_idx;
  logic [1:0] attempts;

  int passCount = 0;
  int checkCount = 0;

  lock_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .in_digit     (in_digit),
    .enter_btn    (enter_btn),
    .set_btn      (set_btn),
    .locked_led   (locked_led),
    .unlocked_led (unlocked_led),
    .error_led    (error_led),
    .lockout_led  (lockout_led),
    .state        (state),
    .digit_idx    (digit_idx),
    .attempts     (attempts)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Safety net so a stuck design can never hang the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before the end of the sequence");
    $fatal(1, "[TB] watchdog");
  end

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Pulse the buttons for one clk; returns just after the edge that acts on
  // the press (two synchroniser flops plus the edge detector).
  task automatic applyStimulus(input logic enterB, input logic setB,
                               input logic [3:0] digit);
    @(negedge clk);
    in_digit  = digit;
    enter_btn = enterB;
    set_btn   = setB;
    @(negedge clk);
    enter_btn = 1'b0;
    set_btn   = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // One clk-wide tick pulse.
  task automatic pulseTick();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic pulseTicks(input int n);
    for (int i = 0; i < n; i++) pulseTick();
  endtask

  // Key in four digits, MSD first; returns on the clk after the fourth capture.
  task automatic enterCode(input logic [15:0] code);
    logic [15:0] c;
    c = code;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, c[15-4*i -: 4]);
  endtask

  task automatic checkLeds(input string tag, input logic [3:0] exp);
    checkOutput(tag, {12'h0, locked_led, unlocked_led, error_led, lockout_led}, {12'h0, exp});
  endtask

  initial begin
    reset     = 1'b1;
    tick      = 1'b0;
    in_digit  = 4'd0;
    enter_btn = 1'b0;
    set_btn   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_state", 16'(state), 16'd0);
    checkOutput("reset_idx", 16'(digit_idx), 16'd0);
    checkOutput("reset_attempts", 16'(attempts), 16'd0);
    checkLeds("reset_leds", 4'b1000);
    reset = 1'b0;
    @(negedge clk);

    // Correct code opens after a single VERIFY clk.
    applyStimulus(1'b1, 1'b0, 4'd1);
    checkOutput("first_digit_state", 16'(state), 16'd1);
    checkOutput("first_digit_idx", 16'(digit_idx), 16'd1);
    applyStimulus(1'b1, 1'b0, 4'd2);
    applyStimulus(1'b1, 1'b0, 4'd3);
    checkOutput("third_digit_idx", 16'(digit_idx), 16'd3);
    applyStimulus(1'b1, 1'b0, 4'd4);
    checkOutput("verify_state", 16'(state), 16'd2);
    checkOutput("verify_idx_wrap", 16'(digit_idx), 16'd0);
    @(negedge clk);
    checkOutput("open_state", 16'(state), 16'd3);
    checkOutput("open_attempts", 16'(attempts), 16'd0);
    checkLeds("open_leds", 4'b0100);
    applyStimulus(1'b1, 1'b0, 4'd0);
    checkOutput("open_enter_relock", 16'(state), 16'd0);

    // Wrong code: error for two ticks, then locked.
    enterCode(16'h1235);
    checkOutput("wrong_verify", 16'(state), 16'd2);
    @(negedge clk);
    checkOutput("error_state", 16'(state), 16'd4);
    checkOutput("error_attempts", 16'(attempts), 16'd1);
    checkLeds("error_leds", 4'b0010);
    applyStimulus(1'b1, 1'b0, 4'd7);
    checkOutput("error_ignores_press", 16'(state), 16'd4);
    pulseTick();
    checkOutput("error_after_1tick", 16'(state), 16'd4);
    pulseTick();
    checkOutput("error_after_2ticks", 16'(state), 16'd0);

    // Second and third failures reach lockout.
    enterCode(16'h1235);
    @(negedge clk);
    checkOutput("second_fail_attempts", 16'(attempts), 16'd2);
    checkOutput("second_fail_state", 16'(state), 16'd4);
    pulseTicks(2);
    enterCode(16'h0000);
    @(negedge clk);
    checkOutput("lockout_state", 16'(state), 16'd5);
    checkOutput("lockout_attempts", 16'(attempts), 16'd3);
    checkLeds("lockout_leds", 4'b0011);
    applyStimulus(1'b1, 1'b0, 4'd1);
    applyStimulus(1'b0, 1'b1, 4'd1);
    checkOutput("lockout_ignores_press", 16'(state), 16'd5);
    checkOutput("lockout_idx_static", 16'(digit_idx), 16'd0);
    pulseTicks(19);
    checkOutput("lockout_after_19", 16'(state), 16'd5);
    pulseTick();
    checkOutput("lockout_done_state", 16'(state), 16'd0);
    checkOutput("lockout_done_attempts", 16'(attempts), 16'd0);

    // Program a new code; the open timer restarts after programming.
    enterCode(16'h1234);
    @(negedge clk);
    checkOutput("reopen_state", 16'(state), 16'd3);
    pulseTicks(5);
    checkOutput("open_partial_ticks", 16'(state), 16'd3);
    applyStimulus(1'b0, 1'b1, 4'd0);
    checkOutput("program_state", 16'(state), 16'd6);
    checkOutput("program_idx", 16'(digit_idx), 16'd0);
    checkLeds("program_leds", 4'b0100);
    applyStimulus(1'b1, 1'b0, 4'd9);
    applyStimulus(1'b1, 1'b0, 4'd8);
    applyStimulus(1'b1, 1'b0, 4'd7);
    checkOutput("program_idx3", 16'(digit_idx), 16'd3);
    applyStimulus(1'b1, 1'b0, 4'd6);
    checkOutput("program_done_state", 16'(state), 16'd3);
    pulseTicks(9);
    checkOutput("open_after_9", 16'(state), 16'd3);
    pulseTick();
    checkOutput("open_timeout", 16'(state), 16'd0);
    enterCode(16'h1234);
    @(negedge clk);
    checkOutput("old_code_rejected", 16'(state), 16'd4);
    checkOutput("old_code_attempts", 16'(attempts), 16'd1);
    pulseTicks(2);
    enterCode(16'h9876);
    @(negedge clk);
    checkOutput("new_code_opens", 16'(state), 16'd3);
    checkOutput("new_code_attempts", 16'(attempts), 16'd0);

    // Abort programming, then enter and set together relocks.
    applyStimulus(1'b0, 1'b1, 4'd0);
    applyStimulus(1'b1, 1'b0, 4'd1);
    applyStimulus(1'b1, 1'b0, 4'd1);
    checkOutput("abort_pre_idx", 16'(digit_idx), 16'd2);
    applyStimulus(1'b0, 1'b1, 4'd1);
    checkOutput("abort_state", 16'(state), 16'd3);
    checkOutput("abort_idx", 16'(digit_idx), 16'd0);
    applyStimulus(1'b1, 1'b1, 4'd0);
    checkOutput("enter_beats_set", 16'(state), 16'd0);
    enterCode(16'h9876);
    @(negedge clk);
    checkOutput("code_kept_after_abort", 16'(state), 16'd3);
    applyStimulus(1'b1, 1'b0, 4'd0);

    // Set is ignored in LOCKED; a long hold is a single press.
    applyStimulus(1'b0, 1'b1, 4'd0);
    checkOutput("set_ignored_locked", 16'(state), 16'd0);
    @(negedge clk);
    in_digit  = 4'd5;
    enter_btn = 1'b1;
    repeat (50) @(negedge clk);
    enter_btn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("hold_state", 16'(state), 16'd1);
    checkOutput("hold_idx", 16'(digit_idx), 16'd1);
    applyStimulus(1'b1, 1'b0, 4'd6);
    checkOutput("second_digit_idx", 16'(digit_idx), 16'd2);

    // Asynchronous reset mid-entry restores the default code.
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_state", 16'(state), 16'd0);
    checkOutput("async_reset_idx", 16'(digit_idx), 16'd0);
    checkLeds("async_reset_leds", 4'b1000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    enterCode(16'h1234);
    @(negedge clk);
    checkOutput("default_after_reset", 16'(state), 16'd3);

    // Reset during programming leaves the default code in place.
    applyStimulus(1'b0, 1'b1, 4'd0);
    applyStimulus(1'b1, 1'b0, 4'd4);
    applyStimulus(1'b1, 1'b0, 4'd4);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("program_reset_state", 16'(state), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    enterCode(16'h1234);
    checkOutput("program_reset_verify", 16'(state), 16'd2);
    @(negedge clk);
    checkOutput("program_reset_opens", 16'(state), 16'd3);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
